rob_param: RTL

//  Parametrised reorder buffer for the out-of-order RISC-V core. Allocates one entry per

---
 rtl/rob_param.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/rob_param.sv
// Reorder buffer: in-order allocate, out-of-order complete, in-order retire.
// Supports multi-port writeback, multi-wide commit and mispredict truncation.
module rob_param #(
  parameter int DEPTH    = 16,
  parameter int TAG_W    = $clog2(DEPTH),
  parameter int PREG_W   = 7,
  parameter int WB_PORTS = 3,
  parameter int COMMIT_W = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [PREG_W-1:0]            disp_pd_new,
  input  logic [PREG_W-1:0]            disp_pd_old,
  input  logic [31:0]                  disp_pc,
  output logic [TAG_W-1:0]             disp_tag,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
  input  logic                         flush_valid,
  input  logic [TAG_W-1:0]             flush_tag,
  output logic [COMMIT_W-1:0]          commit_valid,
  output logic [COMMIT_W*PREG_W-1:0]   commit_pd_old,
  output logic [COMMIT_W*PREG_W-1:0]   commit_pd_new,
  output logic [COMMIT_W*32-1:0]       commit_pc,
  output logic [TAG_W:0]               count,
  output logic                         empty,
  output logic                         full
);

  localparam int PW = TAG_W + 1;

  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [DEPTH-1:0]  cmp_q, cmp_d;
  logic [PREG_W-1:0] pdn_q [DEPTH];
  logic [PREG_W-1:0] pdo_q [DEPTH];
  logic [31:0]       pc_q  [DEPTH];

  logic [TAG_W-1:0]  head_idx;
  logic [TAG_W-1:0]  tail_idx;
  logic [TAG_W-1:0]  flush_off;
  logic [TAG_W-1:0]  c_idx;
  logic [TAG_W-1:0]  w_idx;
  logic [TAG_W-1:0]  age;
  logic              run;
  logic [PW-1:0]     n_commit;
  logic              disp_fire;

  assign head_idx   = head_q[TAG_W-1:0];
  assign tail_idx   = tail_q[TAG_W-1:0];
  assign flush_off  = flush_tag - head_idx;

  assign count      = tail_q - head_q;
  assign empty      = (tail_q == head_q);
  assign full       = (tail_q[TAG_W] != head_q[TAG_W]) &&
                      (tail_idx == head_idx);
  assign disp_ready = !full && !flush_valid;
  assign disp_fire  = disp_valid && disp_ready;
  assign disp_tag   = tail_idx;

  // Retire a contiguous completed prefix; a flush caps it at the branch.
  always_comb begin
    commit_valid  = '0;
    commit_pd_old = '0;
    commit_pd_new = '0;
    commit_pc     = '0;
    n_commit      = '0;
    run           = 1'b1;
    c_idx         = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      c_idx = head_idx + TAG_W'(i);
      run   = run && (PW'(i) < count) && vld_q[c_idx] && cmp_q[c_idx] &&
              !(flush_valid && (TAG_W'(i) > flush_off));
      commit_valid[i] = run;
      commit_pd_old[i*PREG_W +: PREG_W] = pdo_q[c_idx];
      commit_pd_new[i*PREG_W +: PREG_W] = pdn_q[c_idx];
      commit_pc[i*32 +: 32]             = pc_q[c_idx];
      n_commit = n_commit + PW'(run);
    end
  end

  always_comb begin
    vld_d  = vld_q;
    cmp_d  = cmp_q;
    head_d = head_q + n_commit;
    tail_d = tail_q;
    w_idx  = '0;
    age    = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      w_idx = wb_tag[p*TAG_W +: TAG_W];
      if (wb_valid[p] && vld_q[w_idx]) begin
        cmp_d[w_idx] = 1'b1;
      end
    end
    for (int i = 0; i < COMMIT_W; i++) begin
      if (commit_valid[i]) begin
        vld_d[head_idx + TAG_W'(i)] = 1'b0;
        cmp_d[head_idx + TAG_W'(i)] = 1'b0;
      end
    end
    // Squash after writeback so a same-cycle wb cannot revive an entry.
    if (flush_valid) begin
      tail_d = head_q + PW'(flush_off) + PW'(1);
      for (int j = 0; j < DEPTH; j++) begin
        age = TAG_W'(j) - head_idx;
        if (age > flush_off) begin
          vld_d[j] = 1'b0;
          cmp_d[j] = 1'b0;
        end
      end
    end else if (disp_fire) begin
      tail_d          = tail_q + PW'(1);
      vld_d[tail_idx] = 1'b1;
      cmp_d[tail_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      vld_q  <= '0;
      cmp_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      vld_q  <= vld_d;
      cmp_q  <= cmp_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) begin
        pdn_q[j] <= '0;
        pdo_q[j] <= '0;
        pc_q[j]  <= '0;
      end
    end else if (disp_fire) begin
      pdn_q[tail_idx] <= disp_pd_new;
      pdo_q[tail_idx] <= disp_pd_old;
      pc_q[tail_idx]  <= disp_pc;
    end
  end

endmodule
